mem_stage_access: RTL and testbench
===================================

// Module: mem_stage_access
// PURPOSE
// - MEM-stage consumer of the EX/MEM register: turns latched ALU result, store data, mem_read/mem_write and bhw_type into a data-memory transaction.
// - Drives a variable-latency req/ack word port with byte enables; on loads, returns aligned, extended data toward MEM/WB.
// - Raises o_stall while a transaction is outstanding so the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM.
// PARAMETERS
// - ADDR_W    32  byte-address width taken from i_alu_result[ADDR_W-1:0]
// - TIMEOUT   16  max cycles waiting for i_dmem_ack before bus error (>=2)
// PORTS
// - i_clk          in   1   clock
// - i_reset        in   1   asynchronous, active-high reset
// - i_clk_en       in   1   step enable; FSM and counters advance only when high
// - i_alu_result   in   32  byte address from EX/MEM
// - i_write_data   in   32  store data from EX/MEM (unaligned, low bits significant)
// - i_mem_read     in   1   load request from EX/MEM
// - i_mem_write    in   1   store request from EX/MEM
// - i_bhw_type     in   3   000 B, 001 H, 010 W, 011 BU, 100 HU (stores use only 000/001/010)
// - o_dmem_req     out  1   transaction request, held until ack
// - o_dmem_we      out  1   1 = write
// - o_dmem_addr    out  ADDR_W-2  word address (i_alu_result[ADDR_W-1:2])
// - o_dmem_be      out  4   byte enables (bit n = byte lane n, little-endian)
// - o_dmem_wdata   out  32  store data replicated into the addressed lane(s)
// - i_dmem_rdata   in   32  read word, valid with i_dmem_ack
// - i_dmem_ack     in   1   one-cycle completion pulse
// - o_stall        out  1   freeze upstream pipeline
// - o_load_data    out  32  aligned, sign/zero-extended load result
// - o_misaligned   out  1   one-cycle pulse: H at odd addr or W at addr[1:0]!=0; access suppressed
// - o_bus_error    out  1   one-cycle pulse: TIMEOUT expired
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; timeout counter 0; o_load_data 0.
// - Access = i_mem_read | i_mem_write; both high is treated as a write.
// - IDLE: if access & aligned -> o_stall=1 combinationally this cycle; at next enabled edge -> BUSY, o_dmem_req=1, address/be/wdata/we registered from inputs.
// - IDLE, access & misaligned: no req, no stall; o_misaligned pulses at the next enabled edge; o_load_data unchanged.
// - BUSY: o_stall=1, req held stable; counter increments each enabled cycle.
//   - i_dmem_ack: req drops next edge; loads capture extended data into o_load_data; -> DONE.
//   - counter reaches TIMEOUT-1 without ack: req drops, o_bus_error pulses, o_load_data=0 -> DONE.
// - DONE: o_stall=0 for exactly one cycle so EX/MEM captures the next instruction; no new request issued; -> IDLE.
// - Latency with immediate ack (ack on first BUSY cycle): stall high 2 cycles, data valid in DONE.
// - Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; loads also drive be.
// - Load extend: B/H sign-extend bit 7/15 of selected lane; BU/HU zero-extend; W pass-through.
// - i_clk_en low: all state, counter and outputs hold; ack arriving while disabled is ignored (memory must hold ack-valid; the bench never does this).
// - Reset mid-BUSY: req drops immediately (async), transaction abandoned; no error pulse.
// - Undefined bhw_type (101-111): treated as W.
// STRUCTURE
// - Shared package: bhw_type encodings (BHW_B/H/W/BU/HU), FSM state enum {IDLE,BUSY,DONE}.
// - One combinational sub-module mem_lane_align: (addr[1:0], bhw, wdata, rdata) -> (be, wdata_rep, load_ext, misaligned); reused by a future MEM-stage forwarding path.
// - FSM, timeout counter and output registers in this module.
// TESTING
// - SW addr 0x10 data 0xDEADBEEF, ack on 1st BUSY cycle -> be=1111, addr=0x4, wdata=0xDEADBEEF, stall high 2 cycles then low 1.
// - SB addr 0x13 data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, we=1.
// - LB addr 0x21, rdata 0x0000_80FF -> o_load_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x22 rdata 0x8001_0000 -> 0xFFFF8001.
// - LW addr 0x06 -> no req, no stall, o_misaligned pulse 1 cycle.
// - LW with ack never arriving, TIMEOUT=16 -> req high 16 cycles, o_bus_error pulse, o_load_data=0, stall releases.
// - Assert i_reset during BUSY -> req/stall 0 same cycle; after release, new SW issues normally; i_clk_en low 3 cycles in BUSY -> req held, counter frozen.

Source files
------------

// File: rtl/mem_stage_access_pkg.sv
// Shared encodings for the MEM-stage data access path: load/store width
// codes, the access FSM states and a helper that maps a width code to a
// transfer size.
package mem_stage_access_pkg;

    // Load/store width as carried down the pipeline in EX/MEM.
    typedef enum logic [2:0] {
        BHW_B  = 3'b000,
        BHW_H  = 3'b001,
        BHW_W  = 3'b010,
        BHW_BU = 3'b011,
        BHW_HU = 3'b100
    } bhw_t;

    // Access sequencing: wait for a request, hold it on the bus, then
    // release the pipeline for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Transfer size derived from the width code.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam int WORD_W = 32;

    // Signed and unsigned variants share a size; unknown codes fall back to
    // a full word so a corrupted code never produces a partial write.
    function automatic size_t bhw_size(input logic [2:0] bhw);
        case (bhw)
            BHW_B, BHW_BU: return SZ_B;
            BHW_H, BHW_HU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_access_lane.sv
// Combinational byte-lane steering for a 32-bit little-endian word port:
// byte enables, store-data replication, load alignment/extension and the
// alignment check. Kept separate so other MEM-stage paths can reuse it.
module mem_lane_align
    import mem_stage_access_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        bhw,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [WORD_W-1:0] wdata_rep,
    output logic [WORD_W-1:0] load_ext,
    output logic              misaligned
);

    size_t       size;
    logic        sign_ext;
    logic [15:0] lane;

    assign size     = bhw_size(bhw);
    assign sign_ext = (bhw == BHW_B) || (bhw == BHW_H);
    // Bring the addressed byte/halfword down to bit 0.
    assign lane     = 16'(rdata >> {addr_lo, 3'b000});

    // Per-size lane steering; word is the default for any unknown code.
    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        load_ext   = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_ext  = {{24{sign_ext & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                be         = 4'b0011 << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
                load_ext   = {{16{sign_ext & lane[15]}}, lane[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data access: converts the EX/MEM load/store into a request on a
// variable-latency req/ack word port, stalls the upstream pipeline while the
// transaction is outstanding and returns aligned, extended load data.
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_write_data,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_bhw_type,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-3:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [31:0]       o_dmem_wdata,
    input  logic [31:0]       i_dmem_rdata,
    input  logic              i_dmem_ack,
    output logic              o_stall,
    output logic [31:0]       o_load_data,
    output logic              o_misaligned,
    output logic              o_bus_error
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bhw_q;
    logic [1:0]       addr_lo_q;

    logic             access;
    logic [1:0]       al_addr_lo;
    logic [2:0]       al_bhw;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_load;
    logic             al_mis;

    assign access = i_mem_read | i_mem_write;

    // While busy the steering works from the latched access so load
    // extension does not depend on EX/MEM staying frozen.
    assign al_addr_lo = (state == BUSY) ? addr_lo_q : i_alu_result[1:0];
    assign al_bhw     = (state == BUSY) ? bhw_q     : i_bhw_type;

    mem_lane_align u_align (
        .addr_lo    (al_addr_lo),
        .bhw        (al_bhw),
        .wdata      (i_write_data),
        .rdata      (i_dmem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .load_ext   (al_load),
        .misaligned (al_mis)
    );

    // Stall starts combinationally on an aligned access so EX/MEM freezes
    // in the same cycle; reset forces it low immediately.
    assign o_stall = ~i_reset &
                     ((state == BUSY) | ((state == IDLE) & access & ~al_mis));

    // Access FSM with its timeout counter and all registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bhw_q        <= 3'b000;
            addr_lo_q    <= 2'b00;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= 4'b0000;
            o_dmem_wdata <= 32'h0;
            o_load_data  <= 32'h0;
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
        end else if (i_clk_en) begin
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (al_mis) begin
                            o_misaligned <= 1'b1;
                        end else begin
                            state        <= BUSY;
                            cnt          <= '0;
                            o_dmem_req   <= 1'b1;
                            // A simultaneous read+write is treated as a store.
                            o_dmem_we    <= i_mem_write;
                            o_dmem_addr  <= i_alu_result[ADDR_W-1:2];
                            o_dmem_be    <= al_be;
                            o_dmem_wdata <= al_wdata;
                            bhw_q        <= i_bhw_type;
                            addr_lo_q    <= i_alu_result[1:0];
                        end
                    end
                end
                BUSY: begin
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        state      <= DONE;
                        if (!o_dmem_we)
                            o_load_data <= al_load;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        o_dmem_req  <= 1'b0;
                        o_bus_error <= 1'b1;
                        o_load_data <= 32'h0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // One unstalled cycle lets EX/MEM advance; never issue here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: directed cases with literal expectations plus
// randomized loads/stores against a transaction-level model of the port.
module tb_mem_stage_access;

    localparam int TIMEOUT = 16;

    logic        i_clk = 1'b0;
    logic        i_reset, i_clk_en;
    logic [31:0] i_alu_result, i_write_data, i_dmem_rdata;
    logic        i_mem_read, i_mem_write, i_dmem_ack;
    logic [2:0]  i_bhw_type;
    logic        o_dmem_req, o_dmem_we, o_stall, o_misaligned, o_bus_error;
    logic [29:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata, o_load_data;

    always #5 i_clk = ~i_clk;

    mem_stage_access #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_en     (i_clk_en),
        .i_alu_result (i_alu_result),
        .i_write_data (i_write_data),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_bhw_type   (i_bhw_type),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_rdata (i_dmem_rdata),
        .i_dmem_ack   (i_dmem_ack),
        .o_stall      (o_stall),
        .o_load_data  (o_load_data),
        .o_misaligned (o_misaligned),
        .o_bus_error  (o_bus_error)
    );

    int checks = 0, failures = 0;
    bit chk_on = 0;

    // Expected outputs for the current cycle, set by the driver.
    logic        exp_req, exp_stall, exp_mis, exp_berr, exp_we;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;

    // Observations for the literal checks.
    int          req_cycles, stall_cycles, mis_cycles, berr_cycles;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [29:0] cap_addr;
    logic        cap_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_obs();
        req_cycles = 0; stall_cycles = 0; mis_cycles = 0; berr_cycles = 0;
        cap_be = 'x; cap_wdata = 'x; cap_addr = 'x; cap_we = 'x;
    endtask

    // ---- behavioural model of the lane rules ----
    function automatic int m_size(input logic [2:0] t);
        if (t == 3'b000 || t == 3'b011) return 1;
        if (t == 3'b001 || t == 3'b100) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [1:0] a);
        int s;
        logic [3:0] r;
        s = m_size(t);
        r = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (s == 4 || (i >= int'(a) && i < int'(a) + s)) r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit m_mis(input logic [2:0] t, input logic [1:0] a);
        return (int'(a) % m_size(t)) != 0;
    endfunction

    function automatic logic [31:0] m_wrep(input logic [2:0] t, input logic [31:0] d);
        int s;
        logic [31:0] r;
        s = m_size(t);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] t, input logic [1:0] a, input logic [31:0] rd);
        int s;
        longint v, span;
        s    = m_size(t);
        span = longint'(1) << (8 * s);
        v    = longint'(rd >> (8 * int'(a))) % span;
        if ((t == 3'b000 || t == 3'b001) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---- per-cycle compare against the model expectations ----
    initial begin
        forever begin
            @(negedge i_clk);
            if (chk_on) begin
                chk("req", 32'(o_dmem_req), 32'(exp_req));
                chk("stall", 32'(o_stall), 32'(exp_stall));
                chk("misaligned", 32'(o_misaligned), 32'(exp_mis));
                chk("bus_error", 32'(o_bus_error), 32'(exp_berr));
                chk("load_data", o_load_data, exp_load);
                if (exp_req) begin
                    chk("we", 32'(o_dmem_we), 32'(exp_we));
                    chk("addr", 32'(o_dmem_addr), 32'(exp_addr));
                    chk("be", 32'(o_dmem_be), 32'(exp_be));
                    if (exp_we) chk("wdata", o_dmem_wdata, exp_wdata);
                end
                if (o_dmem_req) begin
                    req_cycles++;
                    cap_be = o_dmem_be; cap_wdata = o_dmem_wdata;
                    cap_addr = o_dmem_addr; cap_we = o_dmem_we;
                end
                if (o_stall) stall_cycles++;
                if (o_misaligned) mis_cycles++;
                if (o_bus_error) berr_cycles++;
            end
        end
    end

    // One EX/MEM instruction through the port. mode: 0 steady enable,
    // 1 random enable drops in BUSY, 2 three disabled cycles after 4 busy steps.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic rd,
                           input logic wr, input logic [2:0] t, input int ack_at,
                           input logic [31:0] rdat, input int mode);
        bit acc, mis, en, ak, tout;
        int k, guard, held;
        acc = rd | wr;
        mis = m_mis(t, a[1:0]);
        i_alu_result = a; i_write_data = d; i_mem_read = rd; i_mem_write = wr;
        i_bhw_type = t; i_clk_en = 1'b1; i_dmem_ack = 1'b0;
        exp_req = 0; exp_mis = 0; exp_berr = 0; exp_stall = acc && !mis;
        @(posedge i_clk); #1;
        if (!acc) return;
        if (mis) begin
            i_mem_read = 0; i_mem_write = 0;
            exp_mis = 1; exp_stall = 0;
            @(posedge i_clk); #1;
            exp_mis = 0;
            return;
        end
        exp_req = 1; exp_stall = 1; exp_we = wr; exp_addr = a[31:2];
        exp_be = m_be(t, a[1:0]); exp_wdata = m_wrep(t, d);
        k = 0; guard = 0; held = 0; tout = 0;
        forever begin
            en = 1;
            if (mode == 1 && $urandom_range(0, 7) == 0) en = 0;
            if (mode == 2 && k == 4 && held < 3) begin en = 0; held++; end
            ak = en && (k == ack_at);
            i_clk_en = en; i_dmem_ack = ak;
            i_dmem_rdata = ak ? rdat : $urandom;
            @(posedge i_clk); #1;
            guard++;
            if (ak) break;
            if (en) begin
                if (k == TIMEOUT - 1) begin tout = 1; break; end
                k++;
            end
            if (guard > 200) begin
                checks++; failures++;
                $display("FAIL busy_bound actual=%0d cycles required<=200", guard);
                break;
            end
        end
        i_clk_en = 1; i_dmem_ack = 0; i_mem_read = 0; i_mem_write = 0;
        exp_req = 0; exp_stall = 0; exp_berr = tout;
        if (tout) exp_load = 32'h0;
        else if (rd && !wr) exp_load = m_ext(t, a[1:0], rdat);
        @(posedge i_clk); #1;
        exp_berr = 0;
    endtask

    initial begin
        logic [31:0] ra;
        int sel;
        i_reset = 1; i_clk_en = 0; i_alu_result = 0; i_write_data = 0;
        i_mem_read = 0; i_mem_write = 0; i_bhw_type = 0; i_dmem_rdata = 0; i_dmem_ack = 0;
        exp_req = 0; exp_stall = 0; exp_mis = 0; exp_berr = 0; exp_we = 0;
        exp_addr = 0; exp_be = 0; exp_wdata = 0; exp_load = 0;
        clear_obs();

        #3;
        chk("rst_req", 32'(o_dmem_req), 0);
        chk("rst_stall", 32'(o_stall), 0);
        chk("rst_we", 32'(o_dmem_we), 0);
        chk("rst_be", 32'(o_dmem_be), 0);
        chk("rst_addr", 32'(o_dmem_addr), 0);
        chk("rst_wdata", o_dmem_wdata, 0);
        chk("rst_load", o_load_data, 0);
        chk("rst_mis", 32'(o_misaligned), 0);
        chk("rst_berr", 32'(o_bus_error), 0);
        @(posedge i_clk); #1;
        i_reset = 0; chk_on = 1;

        // SW, ack on first busy cycle
        clear_obs();
        run_txn(32'h10, 32'hDEADBEEF, 0, 1, 3'b010, 0, 32'h0, 0);
        chk("sw_be", 32'(cap_be), 32'h0000000F);
        chk("sw_addr", 32'(cap_addr), 32'h4);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_stall_cycles", stall_cycles, 2);

        // SB to lane 3
        clear_obs();
        run_txn(32'h13, 32'h000000A5, 0, 1, 3'b000, 1, 32'h0, 0);
        chk("sb_be", 32'(cap_be), 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("sb_we", 32'(cap_we), 1);

        // Extended loads
        run_txn(32'h21, 32'h0, 1, 0, 3'b000, 1, 32'h000080FF, 0);
        chk("lb_data", o_load_data, 32'hFFFFFF80);
        run_txn(32'h21, 32'h0, 1, 0, 3'b011, 0, 32'h000080FF, 0);
        chk("lbu_data", o_load_data, 32'h00000080);
        run_txn(32'h22, 32'h0, 1, 0, 3'b001, 2, 32'h80010000, 0);
        chk("lh_data", o_load_data, 32'hFFFF8001);

        // Misaligned word load
        clear_obs();
        run_txn(32'h06, 32'h0, 1, 0, 3'b010, 0, 32'h0, 0);
        chk("lw_mis_pulses", mis_cycles, 1);
        chk("lw_mis_req", req_cycles, 0);
        chk("lw_mis_stall", stall_cycles, 0);
        chk("lw_mis_keep_load", o_load_data, 32'hFFFF8001);

        // Timeout on a load
        clear_obs();
        run_txn(32'h40, 32'h0, 1, 0, 3'b010, 99, 32'h0, 0);
        chk("to_req_cycles", req_cycles, 16);
        chk("to_berr_pulses", berr_cycles, 1);
        chk("to_load_zero", o_load_data, 32'h0);
        chk("to_stall_rel", 32'(o_stall), 0);

        // Reset while a store is outstanding
        i_alu_result = 32'h40; i_write_data = 32'h12345678; i_mem_write = 1;
        i_bhw_type = 3'b010; i_clk_en = 1; exp_stall = 1; exp_req = 0;
        @(posedge i_clk); #1;
        exp_req = 1; exp_we = 1; exp_addr = 30'h10; exp_be = 4'hF; exp_wdata = 32'h12345678;
        @(posedge i_clk); #1;
        i_reset = 1; exp_req = 0; exp_stall = 0; exp_load = 0;
        #1;
        chk("rst_busy_req", 32'(o_dmem_req), 0);
        chk("rst_busy_stall", 32'(o_stall), 0);
        @(posedge i_clk); #1;
        i_mem_write = 0; i_reset = 0;
        clear_obs();
        run_txn(32'h44, 32'hCAFEF00D, 0, 1, 3'b010, 2, 32'h0, 0);
        chk("post_rst_addr", 32'(cap_addr), 32'h11);
        chk("post_rst_req_cycles", req_cycles, 3);
        chk("post_rst_berr", berr_cycles, 0);

        // Enable held low for 3 cycles mid-BUSY freezes the timeout count
        clear_obs();
        run_txn(32'h80, 32'h0, 1, 0, 3'b010, 99, 32'h0, 2);
        chk("en_hold_req_cycles", req_cycles, 19);
        chk("en_hold_berr", berr_cycles, 1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0: run_txn(ra, $urandom, 1, 0, 3'($urandom_range(0, 7)),
                           ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4), $urandom, 1);
                1: run_txn(ra, $urandom, 0, 1, 3'($urandom_range(0, 2)),
                           ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4), $urandom, 1);
                2: run_txn(ra, $urandom, 1, 1, 3'($urandom_range(0, 2)),
                           $urandom_range(0, 3), $urandom, 1);
                default: run_txn(ra, $urandom, 0, 0, 3'b010, 0, 32'h0, 0);
            endcase
        end

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
